// File: rtl/pwm_sequencer.sv
// PWM duty sequencer: hold / ramp-up / ramp-down / breathe, with duty updates aligned to PWM period ends.
// Optional macro PEAK_DWELL_EN adds a BR_DWELL state that holds the breathe peak for DWELL update ticks.
module pwm_sequencer #(
  parameter int PERIOD   = 256,
  parameter int PRESCALE = 4,
  parameter int DWELL    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       stop,
  input  logic [1:0] mode,
  input  logic [7:0] step,
  input  logic [7:0] level,
  output logic [7:0] duty,
  output logic       busy,
  output logic       done,
  output logic       sync
);

  localparam int PW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int QW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PCNT_MAX = PW'(PERIOD - 1);
  localparam logic [QW-1:0] PRE_MAX  = QW'(PRESCALE - 1);

  // Elaboration-time guard on the configuration.
  if (PRESCALE < 1 || DWELL < 0) begin : g_bad_cfg
    $error("pwm_sequencer: PRESCALE must be >= 1 and DWELL >= 0");
  end

  typedef enum logic [1:0] {
    MODE_HOLD    = 2'b00,
    MODE_UP      = 2'b01,
    MODE_DOWN    = 2'b10,
    MODE_BREATHE = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    IDLE,
    RAMP_UP,
    RAMP_DN,
    BR_UP,
    BR_DN
`ifdef PEAK_DWELL_EN
    , BR_DWELL
`endif
  } state_t;

  state_t         state, state_nxt;
  logic [PW-1:0]  pcnt;
  logic [QW-1:0]  pre;
  logic [7:0]     step_r, level_r;
  logic [7:0]     duty_nxt;
  logic           done_nxt;
  logic           launch;
  logic           tick;
  logic [8:0]     sum9, dif9;
  logic           up_reach, dn_reach, br_bottom;

`ifdef PEAK_DWELL_EN
  localparam int DWW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [DWW-1:0] DWELL_MAX = DWW'((DWELL > 0) ? DWELL - 1 : 0);
  localparam bit DWELL_ON = (DWELL > 0);
  logic [DWW-1:0] dwell_cnt, dwell_nxt;
`endif

  assign sync = (pcnt == PCNT_MAX);
  assign busy = (state != IDLE);
  assign tick = sync && (pre == PRE_MAX);

  // 9-bit arithmetic so overflow/underflow of the 8-bit duty is visible in bit 8.
  assign sum9      = {1'b0, duty} + {1'b0, step_r};
  assign dif9      = {1'b0, duty} - {1'b0, step_r};
  assign up_reach  = (sum9 >= {1'b0, level_r});
  assign dn_reach  = dif9[8] || (dif9[7:0] <= level_r);
  assign br_bottom = (duty <= step_r);

  // NOTE: every register here (including the latched step/level) is cleared on reset,
  // and state is updated with non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pcnt    <= '0;
      pre     <= '0;
      duty    <= 8'h00;
      done    <= 1'b0;
      step_r  <= 8'h00;
      level_r <= 8'h00;
`ifdef PEAK_DWELL_EN
      dwell_cnt <= '0;
`endif
    end else begin
      pcnt  <= sync ? '0 : pcnt + PW'(1);
      state <= state_nxt;
      duty  <= duty_nxt;
      done  <= done_nxt;
`ifdef PEAK_DWELL_EN
      dwell_cnt <= dwell_nxt;
`endif
      if (launch) begin
        step_r  <= (step == 8'h00) ? 8'h01 : step;
        level_r <= level;
        pre     <= '0;
      end else if (busy && sync) begin
        pre <= (pre == PRE_MAX) ? '0 : pre + QW'(1);
      end
    end
  end

  // NOTE: every output of this block gets a default before the case, so no latches are inferred.
  always_comb begin
    state_nxt = state;
    duty_nxt  = duty;
    done_nxt  = 1'b0;
    launch    = 1'b0;
`ifdef PEAK_DWELL_EN
    dwell_nxt = dwell_cnt;
`endif

    if (state != IDLE && stop) begin
      // Abort wins over a coincident tick; duty freezes where it is.
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (start && !stop) begin
            unique case (mode_t'(mode))
              MODE_HOLD: begin
                duty_nxt = level;
                done_nxt = 1'b1;
              end
              MODE_UP: begin
                launch    = 1'b1;
                state_nxt = RAMP_UP;
              end
              MODE_DOWN: begin
                launch    = 1'b1;
                state_nxt = RAMP_DN;
              end
              MODE_BREATHE: begin
                launch    = 1'b1;
                duty_nxt  = 8'h00;
                state_nxt = BR_UP;
              end
              default: ;
            endcase
          end
        end

        RAMP_UP: begin
          if (tick) begin
            if (up_reach) begin
              duty_nxt  = level_r;
              done_nxt  = 1'b1;
              state_nxt = IDLE;
            end else begin
              duty_nxt = sum9[7:0];
            end
          end
        end

        RAMP_DN: begin
          if (tick) begin
            if (dn_reach) begin
              duty_nxt  = level_r;
              done_nxt  = 1'b1;
              state_nxt = IDLE;
            end else begin
              duty_nxt = dif9[7:0];
            end
          end
        end

        BR_UP: begin
          if (tick) begin
            if (up_reach) begin
              duty_nxt = level_r;
`ifdef PEAK_DWELL_EN
              dwell_nxt = '0;
              state_nxt = DWELL_ON ? BR_DWELL : BR_DN;
`else
              state_nxt = BR_DN;
`endif
            end else begin
              duty_nxt = sum9[7:0];
            end
          end
        end

        BR_DN: begin
          if (tick) begin
            if (br_bottom) begin
              duty_nxt  = 8'h00;
              state_nxt = BR_UP;
            end else begin
              duty_nxt = dif9[7:0];
            end
          end
        end

`ifdef PEAK_DWELL_EN
        BR_DWELL: begin
          if (tick) begin
            if (dwell_cnt == DWELL_MAX) begin
              state_nxt = BR_DN;
            end else begin
              dwell_nxt = dwell_cnt + DWW'(1);
            end
          end
        end
`endif

        default: state_nxt = IDLE;
      endcase
    end
  end

endmodule
